// File: rtl/key_event_arbiter.sv
// key_event_arbiter: shared-tick debouncer for active-low keys, with a
// round-robin arbiter that feeds a 4-entry press-event FIFO.
module key_event_arbiter #(
  parameter int NUM_KEYS   = 4,
  parameter int TICK_DIV   = 1_000_000,
  parameter int DEB_TICKS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key_n,
  input  logic                evt_ready,
  input  logic                ovf_clr,
  output logic                evt_valid,
  output logic [1:0]          evt_key,
  output logic [3:0]          press_total,
  output logic                overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_TICKS > 1) ? $clog2(DEB_TICKS) : 1;

  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;
  logic [NUM_KEYS-1:0] lvl;
  logic [NUM_KEYS-1:0] stable;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] pending;
  logic [NUM_KEYS-1:0] gnt;
  logic [NUM_KEYS-1:0] drop;
  logic [DW-1:0]       dcnt [NUM_KEYS];
  logic [PW-1:0]       pcnt;
  logic                tick;

  logic [1:0]          last_grant;
  logic [1:0]          gidx;
  logic                found;

  logic [1:0]          mem [FIFO_DEPTH];
  logic [1:0]          wr_ptr;
  logic [1:0]          rd_ptr;
  logic [2:0]          count;
  logic                full;
  logic                push;
  logic                pop;

  assign lvl  = ~sync2;
  assign tick = (pcnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // press_q pulses on the same edge the stable state flips to pressed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable  <= '0;
      press_q <= '0;
      for (int i = 0; i < NUM_KEYS; i++) dcnt[i] <= '0;
    end else begin
      press_q <= '0;
      if (tick) begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (lvl[i] == stable[i]) begin
            dcnt[i] <= '0;
          end else if (dcnt[i] == DW'(DEB_TICKS - 1)) begin
            stable[i]  <= lvl[i];
            dcnt[i]    <= '0;
            press_q[i] <= lvl[i];
          end else begin
            dcnt[i] <= dcnt[i] + 1'b1;
          end
        end
      end
    end
  end

  assign full = (count == 3'(FIFO_DEPTH));

  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    if (!full) begin
      for (int k = 1; k <= NUM_KEYS; k++) begin
        idx = (int'(last_grant) + k) % NUM_KEYS;
        if (!found && pending[idx]) begin
          found = 1'b1;
          gidx  = 2'(idx);
        end
      end
    end
  end

  assign gnt  = found ? (NUM_KEYS'(1) << gidx) : '0;
  assign drop = press_q & pending & ~gnt;
  assign push = found;
  assign pop  = evt_valid & evt_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      last_grant <= 2'(NUM_KEYS - 1);
      overflow   <= 1'b0;
    end else begin
      pending <= (pending & ~gnt) | press_q;
      if (found) last_grant <= gidx;
      if (|drop) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      press_total <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= gidx;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr      <= rd_ptr + 1'b1;
        press_total <= press_total + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign evt_valid = (count != 3'd0);
  assign evt_key   = mem[rd_ptr];

endmodule
